imem_loader: RTL and testbench

Hardware program loader for the single-cycle CPU. It receives a big-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. Each word is written into instruction memory at consecutive word addresses. The CPU is held in reset until the requested number of words has been written. This block replaces the simulation-only file preload with a synthesizable write path into the instruction memory.

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: assembles big-endian bytes into 32-bit words and writes them to
// instruction memory at consecutive addresses, holding the CPU in reset until done.
module imem_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   words_o
);

  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO_LEN = {(ADDR_W+1){1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [31:0]     r_word;
  logic [1:0]      r_cnt;
  logic [ADDR_W:0] r_words;
  logic [ADDR_W:0] r_len;
  logic            r_ready;
  logic            r_we;
  logic            r_busy;
  logic            r_done;
  logic            r_cpu_rst;

  logic [ADDR_W:0] w_eff_len;
  logic [ADDR_W:0] w_words_inc;
  logic            w_accept;

  // Requests longer than the memory are clamped so the address never wraps.
  always_comb begin
    if (len_i > DEPTH) begin
      w_eff_len = DEPTH;
    end else begin
      w_eff_len = len_i;
    end
  end

  assign w_words_inc = r_words + ONE;
  assign w_accept    = byte_valid_i && r_ready;

  // Loader FSM; output flags are registered alongside each state transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_word    <= 32'd0;
      r_cnt     <= 2'd0;
      r_words   <= ZERO_LEN;
      r_len     <= ZERO_LEN;
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cpu_rst <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_words <= ZERO_LEN;
            r_cnt   <= 2'd0;
            r_len   <= w_eff_len;
            if (w_eff_len == ZERO_LEN) begin
              r_state   <= S_DONE;
              r_ready   <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b1;
            end else begin
              r_state   <= S_RECV;
              r_ready   <= 1'b1;
              r_busy    <= 1'b1;
              r_done    <= 1'b0;
              r_cpu_rst <= 1'b0;
            end
          end
        end
        S_RECV: begin
          if (w_accept) begin
            r_word <= {r_word[23:0], byte_i};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_we    <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_we    <= 1'b0;
          r_words <= w_words_inc;
          r_cnt   <= 2'd0;
          if (w_words_inc == r_len) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b1;
          end else begin
            r_state <= S_RECV;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_ready   <= 1'b0;
          r_we      <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_cpu_rst <= 1'b0;
        end
      endcase
    end
  end

  // Address and data come straight from registers, so they hold steady during the strobe.
  assign byte_ready_o = r_ready;
  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_words[ADDR_W-1:0];
  assign imem_data_o  = r_word;
  assign cpu_rst_o    = r_cpu_rst;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign words_o      = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven and random loads checked against a word-list model.
module tb_imem_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst_i;
  logic              start_i;
  logic [ADDR_W:0]   len_i;
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic              cpu_rst_o;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   words_o;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .cpu_rst_o    (cpu_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .words_o      (words_o)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    int len;
    int mode;
    int exp_writes;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  wr_t         wr_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  ref_q[$];
  logic [31:0] mem [DEPTH];
  vec_t        vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe mid-cycle and mirror it into a bench-side memory.
  always @(negedge clk) begin
    if (imem_we_o) begin
      wr_q.push_back('{int'(imem_addr_o), imem_data_o, cyc});
      mem[imem_addr_o] = imem_data_o;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input int len);
    return (len > DEPTH) ? DEPTH : len;
  endfunction

  function automatic logic [31:0] ref_word(input int k);
    return {ref_q[4*k], ref_q[4*k+1], ref_q[4*k+2], ref_q[4*k+3]};
  endfunction

  task automatic fill_random(input int nbytes);
    logic [7:0] b;
    ref_q.delete();
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      ref_q.push_back(b);
      tx_q.push_back(b);
    end
  endtask

  task automatic start_load(input int len);
    @(negedge clk);
    start_i = 1'b1;
    len_i   = len[ADDR_W:0];
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid.
  task automatic feed(input int mode, input int budget, input bit expect_done,
                      output int first_ready, output int done_cyc);
    int  n;
    bit  v;
    n = 0;
    first_ready = -1;
    done_cyc = -1;
    while (!done_o && n < budget) begin
      if (byte_ready_o && first_ready < 0) begin
        first_ready = cyc;
        chk("cpu_held_during_load", {cpu_rst_o, busy_o, done_o}, 3'b010);
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (tx_q.size() == 0) v = 1'b0;
      byte_valid_i = v;
      byte_i = v ? tx_q[0] : 8'($urandom);
      if (v && byte_ready_o) tx_q.delete(0);
      @(negedge clk);
      n++;
    end
    byte_valid_i = 1'b0;
    if (done_o) done_cyc = cyc;
    if (expect_done) chk("feed_timeout", done_o, 1'b1);
  endtask

  task automatic check_load(input string tag, input int exp_n, input bit timed,
                            input int first_ready, input int done_cyc);
    chk($sformatf("%s nwrites", tag), wr_q.size(), exp_n);
    for (int k = 0; k < exp_n && k < wr_q.size(); k++) begin
      chk($sformatf("%s addr[%0d]", tag, k), wr_q[k].addr, k);
      chk($sformatf("%s data[%0d]", tag, k), wr_q[k].data, ref_word(k));
      if (timed) chk($sformatf("%s wcyc[%0d]", tag, k), wr_q[k].cyc, first_ready + 5*k + 4);
    end
    chk($sformatf("%s final_flags", tag), {done_o, cpu_rst_o, busy_o, byte_ready_o, imem_we_o}, 5'b11000);
    if (exp_n > 0) chk($sformatf("%s words", tag), words_o, exp_n);
    if (timed && exp_n > 0) chk($sformatf("%s load_cycles", tag), done_cyc - first_ready, 5*exp_n);
  endtask

  task automatic run_load(input string tag, input int len, input int mode, input int exp_n);
    int fr, dc;
    wr_q.delete();
    start_load(len);
    feed(mode, 4000, 1'b1, fr, dc);
    check_load(tag, exp_n, mode == 0, fr, dc);
  endtask

  initial begin
    int fr, dc, len, mode;
    int regs[32];
    logic [31:0] ins;

    rst_i = 1'b1;
    start_i = 1'b0;
    len_i = '0;
    byte_i = 8'h00;
    byte_valid_i = 1'b0;

    vecs[0] = '{1, 0, 1};
    vecs[1] = '{2, 1, 2};
    vecs[2] = '{0, 0, 0};
    vecs[3] = '{40, 0, 32};
    vecs[4] = '{3, 2, 3};
    vecs[5] = '{33, 1, 32};

    repeat (2) @(negedge clk);
    chk("reset_values", {byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, cpu_rst_o, busy_o, done_o, words_o},
        {1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0});
    rst_i = 1'b0;

    // Single word from the test plan, timed from the first ready cycle.
    ref_q.delete();
    tx_q.delete();
    ref_q = '{8'h20, 8'h08, 8'h00, 8'h05};
    tx_q  = '{8'h20, 8'h08, 8'h00, 8'h05};
    run_load("single", 1, 0, 1);
    chk("single word value", mem[0], 32'h20080005);

    for (int i = 0; i < 6; i++) begin
      fill_random(4 * vecs[i].exp_writes);
      run_load($sformatf("vec%0d", i), vecs[i].len, vecs[i].mode, vecs[i].exp_writes);
    end

    for (int i = 0; i < 5; i++) begin
      len  = $urandom_range(0, 36);
      mode = $urandom_range(0, 2);
      fill_random(4 * eff_len(len));
      run_load($sformatf("rand%0d", i), len, mode, eff_len(len));
    end

    // Reset after one word and two bytes of the next.
    fill_random(12);
    wr_q.delete();
    start_load(3);
    feed(0, 7, 1'b0, fr, dc);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst outputs", {byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, cpu_rst_o, busy_o, done_o, words_o},
        {1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0});
    chk("midrst nwrites", wr_q.size(), 1);
    chk("midrst mem0", mem[0], ref_word(0));
    fill_random(4);
    run_load("after_rst", 1, 0, 1);

    // Reload from DONE: flags drop on RECV entry, and a start pulse in RECV is ignored.
    fill_random(4);
    wr_q.delete();
    start_load(1);
    chk("reload entry", {done_o, cpu_rst_o, byte_ready_o, busy_o, words_o}, {1'b0, 1'b0, 1'b1, 1'b1, 6'd0});
    start_i = 1'b1;
    len_i = 6'd5;
    @(negedge clk);
    start_i = 1'b0;
    feed(0, 200, 1'b1, fr, dc);
    check_load("reload", 1, 1'b0, fr, dc);

    // Small addi program, then interpret the loaded memory.
    ref_q.delete();
    tx_q.delete();
    foreach (ref_q[i]) ref_q.delete(i);
    begin
      logic [31:0] prog[4];
      prog[0] = 32'h20080005;
      prog[1] = 32'h21090003;
      prog[2] = 32'h212AFFFF;
      prog[3] = 32'h214B0064;
      for (int k = 0; k < 4; k++) begin
        for (int b = 3; b >= 0; b--) begin
          ref_q.push_back(prog[k][8*b +: 8]);
          tx_q.push_back(prog[k][8*b +: 8]);
        end
      end
    end
    run_load("prog", 4, 2, 4);
    repeat (20) @(negedge clk);
    chk("prog cpu released", cpu_rst_o, 1'b1);
    for (int r = 0; r < 32; r++) regs[r] = 0;
    for (int k = 0; k < 4; k++) begin
      ins = mem[k];
      if (ins[31:26] == 6'd8 && ins[20:16] != 5'd0)
        regs[ins[20:16]] = regs[ins[25:21]] + int'($signed(ins[15:0]));
    end
    chk("prog r8", regs[8], 5);
    chk("prog r9", regs[9], 8);
    chk("prog r10", regs[10], 7);
    chk("prog r11", regs[11], 107);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
